// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-slot TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int ERR_CNT_W = 4;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/slot_decoder.sv
// One-hot write-enable decode for the shadow slots; bit NUM_SLOTS-1 marks frame completion.
module slot_decoder
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] wr_en
);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_en = '0;
    if (en) wr_en[slot] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: collects a sync-aligned frame in shadow registers and
// publishes all four channels atomically when the last slot arrives.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 sync,
  output logic [W-1:0]         D0,
  output logic [W-1:0]         D1,
  output logic [W-1:0]         D2,
  output logic [W-1:0]         D3,
  output logic                 frame_valid,
  output logic [SLOT_W-1:0]    S,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t                state, state_nxt;
  logic [SLOT_W-1:0]     slot_nxt;
  logic [SLOT_W-1:0]     wr_slot;
  logic                  wr_req;
  logic                  err;
  logic [NUM_SLOTS-1:0]  wr_en;

  // Slot 3 is never shadowed: it goes straight from din into D3.
  logic [W-1:0] shadow [NUM_SLOTS-1];

  slot_decoder u_slot_decoder (
    .slot  (wr_slot),
    .en    (wr_req),
    .wr_en (wr_en)
  );

  always_comb begin
    state_nxt = state;
    slot_nxt  = S;
    wr_slot   = S;
    wr_req    = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            wr_req    = 1'b1;
            wr_slot   = '0;
            slot_nxt  = SLOT_W'(1);
            state_nxt = RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // A sync mid-frame is an error, but the word still opens a fresh frame.
            wr_req   = 1'b1;
            wr_slot  = '0;
            slot_nxt = SLOT_W'(1);
            err      = (S != '0);
          end else if (S == '0) begin
            err       = 1'b1;
            state_nxt = HUNT;
          end else begin
            wr_req   = 1'b1;
            slot_nxt = S + 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      S           <= '0;
      D0          <= '0;
      D1          <= '0;
      D2          <= '0;
      D3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
      // NOTE: the shadow array is reset too, since it is small and must read 0 after reset.
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
    end else begin
      state       <= state_nxt;
      S           <= slot_nxt;
      frame_valid <= wr_en[NUM_SLOTS-1];
      sync_err    <= err;
      if (err && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 1'b1;
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (wr_en[i]) shadow[i] <= din;
      end
      if (wr_en[NUM_SLOTS-1]) begin
        D0 <= shadow[0];
        D1 <= shadow[1];
        D2 <= shadow[2];
        D3 <= din;
      end
    end
  end

endmodule
